// File: rtl/decode_useq_ctrl_pkg.sv
// rtl/decode_useq_ctrl_pkg.sv - shared widths and state encoding for the micro-op sequencer
package decode_useq_ctrl_pkg;

  localparam int ROM_AW = 6;
  localparam int UCNT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } useq_state_e;

endpackage

// File: rtl/decode_useq_ctrl_if.sv
// rtl/decode_useq_ctrl_if.sv - decoder-to-sequencer instruction handshake
interface decode_useq_ctrl_if #(
  parameter int ROM_AW = decode_useq_ctrl_pkg::ROM_AW,
  parameter int UCNT_W = decode_useq_ctrl_pkg::UCNT_W
);

  logic              de_valid;
  logic [ROM_AW-1:0] de_rom_base;
  logic [UCNT_W-1:0] de_uop_cnt;
  logic              de_rep_pr;
  logic              de_ready;

  modport master (
    output de_valid,
    output de_rom_base,
    output de_uop_cnt,
    output de_rep_pr,
    input  de_ready
  );

  modport slave (
    input  de_valid,
    input  de_rom_base,
    input  de_uop_cnt,
    input  de_rep_pr,
    output de_ready
  );

endinterface

// File: rtl/decode_useq_ctrl_uop_idx_ctr.sv
// rtl/decode_useq_ctrl_uop_idx_ctr.sv - micro-op index counter with terminal compare
module uop_idx_ctr
  import decode_useq_ctrl_pkg::*;
#(
  parameter int W = UCNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_zero_i,
  input  logic         inc_i,
  input  logic [W-1:0] cnt_i,
  output logic [W-1:0] idx_o,
  output logic         last_o
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i || ld_zero_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // cnt is 0 only out of reset, where the wrapped compare keeps last low
  assign last_o = (idx_q == W'(cnt_i - W'(1)));
  assign idx_o  = idx_q;

endmodule

// File: rtl/decode_useq_ctrl.sv
// rtl/decode_useq_ctrl.sv - steps decode ROM address one micro-op per cycle with REP, stall, flush
module decode_useq_ctrl
  import decode_useq_ctrl_pkg::*;
#(
  parameter int ROM_AW = decode_useq_ctrl_pkg::ROM_AW,
  parameter int UCNT_W = decode_useq_ctrl_pkg::UCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_useq_ctrl_if.slave de,
  input  logic              ecx_zero_i,
  input  logic              rep_last_iter_i,
  input  logic              stall_in_i,
  input  logic              flush_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic              uop_valid_o,
  output logic              uop_first_o,
  output logic              uop_last_o,
  output logic [UCNT_W-1:0] uop_idx_o
);

  useq_state_e       state_q, state_d;
  logic [ROM_AW-1:0] base_q, base_d;
  logic [UCNT_W-1:0] cnt_q, cnt_d;
  logic              rep_q, rep_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  logic [UCNT_W-1:0] idx;
  logic              last;

  logic run, iter_end, rep_again, ready_c, accept, load, advance;
  logic ctr_clr, ctr_ld_zero;

  uop_idx_ctr #(.W(UCNT_W)) u_idx_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (ctr_clr),
    .ld_zero_i (ctr_ld_zero),
    .inc_i     (advance),
    .cnt_i     (cnt_q),
    .idx_o     (idx),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (load) state_d = ST_RUN;
        ST_RUN:  if (iter_end && !rep_again && !load) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run         = (state_q == ST_RUN);
    iter_end    = run & ~stall_in_i & last;
    rep_again   = iter_end & rep_q & ~rep_last_iter_i & ~flush_i;
    ready_c     = ~flush_i & (~run | (iter_end & ~(rep_q & ~rep_last_iter_i)));
    accept      = de.de_valid & ready_c;
    // REP with ECX==0 retires the instruction without issuing anything
    load        = accept & ~(de.de_rep_pr & ecx_zero_i);
    advance     = run & ~stall_in_i & ~last & ~flush_i;
    ctr_clr     = flush_i | (iter_end & ~rep_again & ~load);
    ctr_ld_zero = load | rep_again;
  end

  assign de.de_ready = ready_c;

  always_comb begin
    base_d     = base_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    rom_addr_d = rom_addr_q;
    if (load) begin
      base_d     = de.de_rom_base;
      cnt_d      = (de.de_uop_cnt == '0) ? UCNT_W'(1) : de.de_uop_cnt;
      rep_d      = de.de_rep_pr;
      rom_addr_d = de.de_rom_base;
    end else if (rep_again) begin
      rom_addr_d = base_q;
    end else if (advance) begin
      rom_addr_d = base_q + ROM_AW'(idx) + ROM_AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      cnt_q      <= '0;
      rep_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign uop_valid_o = (state_q == ST_RUN);
  assign uop_first_o = (idx == '0);
  assign uop_last_o  = last;
  assign uop_idx_o   = idx;

endmodule

// File: tb/tb_decode_useq_ctrl.sv
// tb/tb_decode_useq_ctrl.sv - directed and random checks of the micro-op sequencer against an instruction-level model
module tb_decode_useq_ctrl;

  localparam int AW = 6;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          ecx_zero, rep_last_iter, stall_in, flush;
  logic [AW-1:0] rom_addr;
  logic          uop_valid, uop_first, uop_last;
  logic [CW-1:0] uop_idx;

  decode_useq_ctrl_if #(.ROM_AW(AW), .UCNT_W(CW)) dif ();

  decode_useq_ctrl #(.ROM_AW(AW), .UCNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .de              (dif),
    .ecx_zero_i      (ecx_zero),
    .rep_last_iter_i (rep_last_iter),
    .stall_in_i      (stall_in),
    .flush_i         (flush),
    .rom_addr_o      (rom_addr),
    .uop_valid_o     (uop_valid),
    .uop_first_o     (uop_first),
    .uop_last_o      (uop_last),
    .uop_idx_o       (uop_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // instruction-level model: what is in flight and which uop of it is showing
  bit m_busy = 0;
  int m_base = 0;
  int m_cnt  = 1;
  bit m_rep  = 0;
  int m_pos  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input int base, input int cnt, input bit rp,
                      input bit ecx, input bit rli, input bit st, input bit fl);
    bit exp_rdy;
    @(negedge clk);
    check("uop_valid", 32'(uop_valid), 32'(m_busy));
    if (m_busy) begin
      check("rom_addr", 32'(rom_addr), 32'((m_base + m_pos) % 64));
      check("uop_first", 32'(uop_first), 32'(m_pos == 0));
      check("uop_last", 32'(uop_last), 32'(m_pos == m_cnt - 1));
      check("uop_idx", 32'(uop_idx), 32'(m_pos));
    end
    dif.de_valid    = v;
    dif.de_rom_base = AW'(base);
    dif.de_uop_cnt  = CW'(cnt);
    dif.de_rep_pr   = rp;
    ecx_zero        = ecx;
    rep_last_iter   = rli;
    stall_in        = st;
    flush           = fl;
    #1;
    exp_rdy = !fl && (!m_busy || (!st && m_pos == m_cnt - 1 && !(m_rep && !rli)));
    check("de_ready", 32'(dif.de_ready), 32'(exp_rdy));
    if (fl) begin
      m_busy = 0;
      m_pos  = 0;
    end else if (m_busy && st) begin
      m_busy = m_busy;
    end else if (m_busy && m_pos < m_cnt - 1) begin
      m_pos++;
    end else if (m_busy && m_rep && !rli) begin
      m_pos = 0;
    end else if (v && exp_rdy && !(rp && ecx)) begin
      m_busy = 1;
      m_base = base;
      m_cnt  = (cnt == 0) ? 1 : cnt;
      m_rep  = rp;
      m_pos  = 0;
    end else begin
      m_busy = 0;
      m_pos  = 0;
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(uop_valid), 32'd0);
    check({tag, "_rom"}, 32'(rom_addr), 32'd0);
    check({tag, "_first"}, 32'(uop_first), 32'd1);
    check({tag, "_last"}, 32'(uop_last), 32'd0);
    check({tag, "_ready"}, 32'(dif.de_ready), 32'd1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    dif.de_valid = 0;
    flush = 0;
    stall_in = 0;
    rst_n = 0;
    #1;
    check_reset_state("rst_mid");
    m_busy = 0;
    m_pos  = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    dif.de_valid = 0; dif.de_rom_base = '0; dif.de_uop_cnt = '0; dif.de_rep_pr = 0;
    ecx_zero = 0; rep_last_iter = 0; stall_in = 0; flush = 0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1;

    // three-uop instruction, no stall
    step(1, 'h10, 3, 0, 0, 0, 0, 0);
    repeat (4) idle_step();
    // back-to-back single then double
    step(1, 'h05, 1, 0, 0, 0, 0, 0);
    step(1, 'h20, 2, 0, 0, 0, 0, 0);
    repeat (3) idle_step();
    // stall held on uop 1
    step(1, 'h08, 3, 0, 0, 0, 0, 0);
    idle_step();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) idle_step();
    // REP over three iterations, then REP with ECX==0
    step(1, 'h30, 2, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, 0, (i == 6), 0, 0);
    step(1, 'h11, 2, 1, 1, 0, 0, 0);
    repeat (2) idle_step();
    // flush on uop 1 with a competing instruction, then address wrap
    step(1, 'h18, 4, 0, 0, 0, 0, 0);
    idle_step();
    step(1, 'h2A, 2, 0, 0, 0, 0, 1);
    idle_step();
    step(1, 'h3F, 2, 0, 0, 0, 0, 0);
    repeat (3) idle_step();
    // zero count acts as one
    step(1, 'h01, 0, 0, 0, 0, 0, 0);
    repeat (2) idle_step();

    // mid-instruction asynchronous reset
    step(1, 'h22, 5, 0, 0, 0, 0, 0);
    idle_step();
    async_reset();

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset();
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 63)),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0);
    end
    idle_step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
